// File: rtl/ets_phase_stepper_if.sv
// Sampler and MMCM-facing signal bundle for ets_phase_stepper.
// The stepper connects through the slave modport; its environment uses master.
interface ets_phase_stepper_if;
    logic        shift;
    logic        shift_done;
    logic        rewind;
    logic        rewind_done;
    logic        psen;
    logic        psincdec;
    logic        psdone;
    logic [31:0] vernier_q;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    modport master (
        output shift, rewind, psdone,
        input  shift_done, rewind_done, psen, psincdec, vernier_q, busy,
               timeout_err, overrun_err
    );

    modport slave (
        input  shift, rewind, psdone,
        output shift_done, rewind_done, psen, psincdec, vernier_q, busy,
               timeout_err, overrun_err
    );
endinterface

// File: rtl/ets_phase_stepper.sv
// Steps the MMCM dynamic phase shifter on sampler shift/rewind requests and tracks the Vernier phase.
// Optional post-shift settle delay is enabled by defining ETS_PS_SETTLE_EN.
module ets_phase_stepper #(
    parameter int unsigned STEPS_PER_SHIFT = 1,
    parameter int unsigned PHASE_PERIOD    = 560,
    parameter int unsigned PSDONE_TIMEOUT  = 255,
    parameter int unsigned SETTLE_CYCLES   = 16
) (
    input  logic               sample_clk,
    input  logic               reset,
    ets_phase_stepper_if.slave bus
);
    localparam int unsigned POS_W = (PHASE_PERIOD > 1) ? $clog2(PHASE_PERIOD) : 1;
    localparam int unsigned REM_W = (POS_W > 8) ? POS_W : 8;
    localparam int unsigned TMR_W = (PSDONE_TIMEOUT > 0) ? $clog2(PSDONE_TIMEOUT + 1) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(PHASE_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(PSDONE_TIMEOUT);

    if (STEPS_PER_SHIFT < 1 || STEPS_PER_SHIFT > 255 || PHASE_PERIOD < 2 ||
        PSDONE_TIMEOUT < 1 || SETTLE_CYCLES > 65535) begin : g_param_check
        $error("ets_phase_stepper: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        WAIT   = 3'd2,
`ifdef ETS_PS_SETTLE_EN
        SETTLE = 3'd4,
`endif
        ACK    = 3'd3
    } state_t;

    state_t           state, state_nx;
    logic [POS_W-1:0] pos, pos_nx;
    logic [REM_W-1:0] rem, rem_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             dir_inc, dir_inc_nx;
    logic             mode_rew, mode_rew_nx;
    logic             timeout_r, timeout_nx;
    logic             overrun_r, overrun_nx;
    logic             psdone_q;
    logic             psen_r, psincdec_r, shift_done_r, rewind_done_r, busy_r;

`ifdef ETS_PS_SETTLE_EN
    localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES);
    logic [SET_W-1:0] settle_cnt, settle_nx;
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_nx    = state;
        pos_nx      = pos;
        rem_nx      = rem;
        tmr_nx      = tmr;
        dir_inc_nx  = dir_inc;
        mode_rew_nx = mode_rew;
        timeout_nx  = timeout_r;
        overrun_nx  = overrun_r;
`ifdef ETS_PS_SETTLE_EN
        settle_nx   = settle_cnt;
`endif
        // A shift that cannot be accepted (busy, or losing to rewind) is dropped and flagged.
        if (bus.shift && (state != IDLE || bus.rewind)) begin
            overrun_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.rewind) begin
                    mode_rew_nx = 1'b1;
                    dir_inc_nx  = 1'b0;
                    if (pos != '0) begin
                        rem_nx   = REM_W'(pos);
                        state_nx = PULSE;
                    end else begin
                        state_nx = ACK;
                    end
                end else if (bus.shift) begin
                    mode_rew_nx = 1'b0;
                    dir_inc_nx  = 1'b1;
                    rem_nx      = REM_W'(STEPS_PER_SHIFT);
                    state_nx    = PULSE;
                end
            end
            PULSE: begin
                tmr_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // psdone wins over a timer expiring in the same cycle.
                if (psdone_q) begin
                    if (dir_inc) begin
                        pos_nx = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                    end else begin
                        pos_nx = (pos == '0) ? POS_MAX : pos - POS_W'(1);
                    end
                    rem_nx = rem - REM_W'(1);
                    if (rem == REM_W'(1)) begin
`ifdef ETS_PS_SETTLE_EN
                        settle_nx = '0;
                        state_nx  = SETTLE;
`else
                        state_nx  = ACK;
`endif
                    end else begin
                        state_nx = PULSE;
                    end
                end else if (tmr == TMR_MAX) begin
                    timeout_nx = 1'b1;
                    state_nx   = ACK;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
`ifdef ETS_PS_SETTLE_EN
            SETTLE: begin
                if (settle_cnt == SET_MAX) begin
                    state_nx = ACK;
                end else begin
                    settle_nx = settle_cnt + SET_W'(1);
                end
            end
`endif
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state         <= IDLE;
            pos           <= '0;
            rem           <= '0;
            tmr           <= '0;
            dir_inc       <= 1'b0;
            mode_rew      <= 1'b0;
            timeout_r     <= 1'b0;
            overrun_r     <= 1'b0;
            psdone_q      <= 1'b0;
            psen_r        <= 1'b0;
            psincdec_r    <= 1'b0;
            shift_done_r  <= 1'b0;
            rewind_done_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef ETS_PS_SETTLE_EN
            settle_cnt    <= '0;
`endif
        end else begin
            state         <= state_nx;
            pos           <= pos_nx;
            rem           <= rem_nx;
            tmr           <= tmr_nx;
            dir_inc       <= dir_inc_nx;
            mode_rew      <= mode_rew_nx;
            timeout_r     <= timeout_nx;
            overrun_r     <= overrun_nx;
            psdone_q      <= bus.psdone && (state == WAIT);
            psen_r        <= (state_nx == PULSE);
            psincdec_r    <= (state_nx == PULSE) && dir_inc_nx;
            shift_done_r  <= (state_nx == ACK) && !mode_rew_nx;
            rewind_done_r <= (state_nx == ACK) && mode_rew_nx;
            busy_r        <= (state_nx != IDLE);
`ifdef ETS_PS_SETTLE_EN
            settle_cnt    <= settle_nx;
`endif
        end
    end

    assign bus.psen        = psen_r;
    assign bus.psincdec    = psincdec_r;
    assign bus.shift_done  = shift_done_r;
    assign bus.rewind_done = rewind_done_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = timeout_r;
    assign bus.overrun_err = overrun_r;
    assign bus.vernier_q   = 32'(pos);
endmodule

// File: tb/tb_ets_phase_stepper.sv
// Directed/randomized bench for ets_phase_stepper with a behavioural MMCM psdone responder.
// Honours ETS_PS_SETTLE_EN when computing expected latencies.
module tb_ets_phase_stepper;
    localparam int STEPS  = 1;
    localparam int PERIOD = 560;
    localparam int TMO    = 20;
    localparam int SETTLE = 16;
`ifdef ETS_PS_SETTLE_EN
    localparam int SETTLE_EXTRA = SETTLE + 1;
`else
    localparam int SETTLE_EXTRA = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ets_phase_stepper_if bus ();

    ets_phase_stepper #(
        .STEPS_PER_SHIFT(STEPS),
        .PHASE_PERIOD   (PERIOD),
        .PSDONE_TIMEOUT (TMO),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .sample_clk(clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_pos = 0;

    int n_psen  = 0;
    int n_inc   = 0;
    int n_dec   = 0;
    int n_sdone = 0;
    int n_rdone = 0;
    int ps_lat  = 12;
    bit ps_silent = 1'b0;
    int ps_cnt  = 0;

    // MMCM model and event monitor: psdone appears ps_lat cycles after the psen cycle.
    always @(negedge clk) begin
        if (bus.psen === 1'b1) begin
            n_psen++;
            if (bus.psincdec === 1'b1) n_inc++;
            else n_dec++;
        end
        if (bus.shift_done === 1'b1)  n_sdone++;
        if (bus.rewind_done === 1'b1) n_rdone++;
        bus.psdone = 1'b0;
        if (ps_cnt > 0) begin
            ps_cnt--;
            if (ps_cnt == 0) bus.psdone = 1'b1;
        end
        if (bus.psen === 1'b1 && !ps_silent) ps_cnt = ps_lat;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " outs"}, 32'({bus.shift_done, bus.rewind_done, bus.psen, bus.psincdec, bus.busy}), 32'd0);
        check({tag, " vernier"}, bus.vernier_q, 32'(exp_pos));
    endtask

    task automatic shift_op(input int lat, input string tag);
        int n;
        int p0;
        ps_lat = lat;
        p0 = n_inc;
        bus.shift = 1'b1;
        tick();
        bus.shift = 1'b0;
        n = 1;
        while (bus.shift_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        exp_pos = (exp_pos + 1) % PERIOD;
        check({tag, " latency"}, 32'(n), 32'(STEPS * (lat + 2) + 1 + SETTLE_EXTRA));
        check({tag, " vernier"}, bus.vernier_q, 32'(exp_pos));
        check({tag, " inc steps"}, 32'(n_inc - p0), 32'(STEPS));
        tick();
    endtask

    task automatic rewind_op(input int lat, input bit with_shift, input string tag);
        int n;
        int d0, i0, r0, s0, start;
        int exp_n;
        ps_lat = lat;
        d0 = n_dec; i0 = n_inc; r0 = n_rdone; s0 = n_sdone;
        start = exp_pos;
        exp_n = (start == 0) ? 1 : start * (lat + 2) + 1 + SETTLE_EXTRA;
        bus.rewind = 1'b1;
        bus.shift  = with_shift;
        tick();
        bus.shift = 1'b0;
        n = 1;
        while (bus.rewind_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        bus.rewind = 1'b0;
        tick();
        exp_pos = 0;
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " dec steps"}, 32'(n_dec - d0), 32'(start));
        check({tag, " inc steps"}, 32'(n_inc - i0), 32'd0);
        check({tag, " rewind_done"}, 32'(n_rdone - r0), 32'd1);
        check({tag, " shift_done"}, 32'(n_sdone - s0), 32'd0);
        check({tag, " vernier"}, bus.vernier_q, 32'd0);
    endtask

    initial begin
        int n;
        int p0;
        int s0;
        int target;
        bus.shift  = 1'b0;
        bus.rewind = 1'b0;

        // Reset state.
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset flags", 32'({bus.timeout_err, bus.overrun_err}), 32'd0);
        reset = 1'b0;
        tick();

        // Basic shift with 12-cycle psdone latency.
        p0 = n_psen;
        shift_op(12, "basic");
        check("basic psen count", 32'(n_psen - p0), 32'd1);

        // Randomized shifts with random psdone latency and gaps.
        for (int i = 0; i < 30; i++) begin
            shift_op(int'($urandom_range(18, 1)), "rand shift");
            repeat ($urandom_range(3, 0)) tick();
        end

        // Rewind from a random position, then from zero.
        target = int'($urandom_range(20, 1));
        while (exp_pos != target) shift_op(int'($urandom_range(6, 1)), "pre rewind");
        rewind_op(int'($urandom_range(10, 1)), 1'b0, "rewind rand");
        repeat (5) shift_op(3, "to five");
        rewind_op(4, 1'b0, "rewind five");
        rewind_op(4, 1'b0, "rewind zero");

        // Full wrap around the phase period.
        p0 = n_psen;
        for (int i = 0; i < PERIOD; i++) begin
            shift_op(int'($urandom_range(4, 1)), "wrap");
        end
        check("wrap psen count", 32'(n_psen - p0), 32'(PERIOD));
        check("wrap flags", 32'({bus.timeout_err, bus.overrun_err}), 32'd0);

        // psdone timeout: abort still acknowledged, position held.
        shift_op(2, "pre timeout");
        ps_silent = 1'b1;
        p0 = n_psen;
        bus.shift = 1'b1;
        tick();
        bus.shift = 1'b0;
        n = 0;
        while (bus.psen !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("timeout psen seen", 32'(bus.psen), 32'd1);
        n = 0;
        while (bus.shift_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("timeout latency", 32'(n), 32'(TMO + 2));
        check("timeout err", 32'(bus.timeout_err), 32'd1);
        check("timeout vernier", bus.vernier_q, 32'(exp_pos));
        check("timeout psen count", 32'(n_psen - p0), 32'd1);
        tick();
        ps_silent = 1'b0;
        shift_op(5, "after timeout");

        // Shift while busy is dropped and flagged.
        check("overrun clear", 32'(bus.overrun_err), 32'd0);
        p0 = n_psen;
        s0 = n_sdone;
        ps_lat = 8;
        bus.shift = 1'b1;
        tick();
        bus.shift = 1'b0;
        repeat (3) tick();
        bus.shift = 1'b1;
        tick();
        bus.shift = 1'b0;
        n = 0;
        while (bus.shift_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        exp_pos = (exp_pos + 1) % PERIOD;
        repeat (40) tick();
        check("overrun err", 32'(bus.overrun_err), 32'd1);
        check("overrun psen count", 32'(n_psen - p0), 32'd1);
        check("overrun shift_done", 32'(n_sdone - s0), 32'd1);
        check("overrun vernier", bus.vernier_q, 32'(exp_pos));

        // Reset clears sticky flags; then rewind beats a simultaneous shift.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pos = 0;
        check("flags after reset", 32'({bus.timeout_err, bus.overrun_err}), 32'd0);
        tick();
        repeat (3) shift_op(int'($urandom_range(9, 1)), "pre combo");
        rewind_op(int'($urandom_range(9, 1)), 1'b1, "combo");
        check("combo overrun", 32'(bus.overrun_err), 32'd1);

        // Reset during WAIT drops the sequence without acknowledging.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pos = 0;
        tick();
        shift_op(3, "pre midreset");
        ps_lat = 15;
        p0 = n_psen;
        s0 = n_sdone;
        bus.shift = 1'b1;
        tick();
        bus.shift = 1'b0;
        repeat (4) tick();
        check("midreset busy before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pos = 0;
        check_idle_outputs("midreset");
        check("midreset flags", 32'({bus.timeout_err, bus.overrun_err}), 32'd0);
        repeat (25) tick();
        check("midreset shift_done", 32'(n_sdone - s0), 32'd0);
        check("midreset psen count", 32'(n_psen - p0), 32'd1);
        check_idle_outputs("midreset later");
        shift_op(6, "post midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ets_phase_stepper.md
Name: ets_phase_stepper

Overview:
- Responder for the ETS sampler's `shift`/`shift_done` handshake.
- On each shift request it drives the MMCM dynamic phase-shift port (`psen`/`psincdec`/`psdone`) for a programmed number of fine steps, then returns a single-cycle `shift_done`.
- Tracks the cumulative Vernier phase position, wrapping modulo one sampling period, and presents it as `vernier_q` to the sampler.
- Supports a rewind-to-zero command between acquisitions.

Parameters:
- STEPS_PER_SHIFT, 1, MMCM fine steps issued per shift request (1..255).
- PHASE_PERIOD, 560, fine steps per full sample period; phase position wraps modulo this value.
- PSDONE_TIMEOUT, 255, cycles to wait for `psdone` after a `psen` pulse before aborting.
- SETTLE_CYCLES, 16, post-shift settle delay; used only with ETS_PS_SETTLE_EN.

Ports:
- sample_clk  in  1  sole clock; the MMCM PSCLK is tied to this clock.
- reset  in  1  synchronous, active-high.
- shift  in  1  one-cycle shift request from the sampler.
- shift_done  out  1  one-cycle acknowledge of a completed shift.
- rewind  in  1  level; while IDLE, step backwards until `vernier_q` equals 0.
- rewind_done  out  1  one-cycle pulse when the rewind sequence finishes.
- psen  out  1  MMCM phase-shift enable, one-cycle pulse.
- psincdec  out  1  1 = increment, 0 = decrement; valid whenever `psen` is 1.
- psdone  in  1  MMCM step-complete pulse.
- vernier_q  out  32  current phase position, 0..PHASE_PERIOD-1, zero-extended.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set when `psdone` never arrives within PSDONE_TIMEOUT.
- overrun_err  out  1  sticky; set when `shift` arrives while `busy` is high.

Behaviour:
- Reset values: all outputs 0, `vernier_q` = 0, state IDLE, internal counters 0. A reset mid-sequence drops the sequence immediately with no `shift_done`; the MMCM itself is not rewound.
- States: IDLE, PULSE, WAIT, SETTLE, ACK.
- IDLE:
  - `rewind` has priority over `shift`.
  - `rewind`=1 and `vernier_q`≠0: load remaining=`vernier_q`, dir=dec, mode=REW, go to PULSE.
  - `rewind`=1 and `vernier_q`=0: pulse `rewind_done` on the next cycle via ACK with mode=REW, issuing no steps.
  - Otherwise `shift`=1: load remaining=STEPS_PER_SHIFT, dir=inc, mode=SH, go to PULSE.
  - If `rewind` and `shift` are asserted in the same cycle, the shift is dropped and `overrun_err` is set.
- PULSE: `psen`=1 for exactly one cycle, `psincdec`=dir; clear the timeout timer; go to WAIT.
- WAIT:
  - On `psdone`: update position (see wrap rules), remaining -= 1. If remaining reaches 0, go to SETTLE when the macro is defined, else ACK. Otherwise go to PULSE.
  - If the timer reaches PSDONE_TIMEOUT without `psdone`: set `timeout_err`, leave position unchanged, go to ACK. The sequence is aborted but still acknowledged, so the sampler never deadlocks.
  - A `psdone` arriving in the same cycle the timer expires counts as success.
  - `psdone` seen in any state other than WAIT is ignored.
- ACK: `shift_done`=1 if mode=SH, or `rewind_done`=1 if mode=REW, for one cycle; then return to IDLE.
- Latency: shift request to `shift_done` is STEPS_PER_SHIFT×(2 + psdone latency) + 1 cycles, plus SETTLE_CYCLES + 1 when the settle feature is enabled.
- Wrap rules:
  - Increment from PHASE_PERIOD-1 goes to 0.
  - Decrement from 0 goes to PHASE_PERIOD-1. This is unreachable during rewind, which always stops at 0.
  - Internal position register is ceil(log2(PHASE_PERIOD)) bits.
- Handshake with the MMCM: `psen` is never asserted again until the previous `psdone` has been received or has timed out.
- `shift` while `busy` is ignored and sets `overrun_err`.
- Sticky flags clear only on `reset`.

Optional Feature:
- Macro: ETS_PS_SETTLE_EN.
- Defined: after the final successful `psdone`, enter SETTLE and count SETTLE_CYCLES cycles before ACK, letting the MMCM output settle before the next acquisition.
  - The timeout path bypasses SETTLE.
  - `busy` stays high during SETTLE.
- Undefined: the SETTLE state and its counter are not built; WAIT goes directly to ACK.

Test Plan:
- Basic shift (STEPS_PER_SHIFT=1, psdone model returns the pulse 12 cycles after `psen`, macro off): one `shift` -> exactly one `psen` with `psincdec`=1, `shift_done` 15 cycles after `shift`, `vernier_q` = 1.
- Wrap: 560 consecutive shifts -> `vernier_q` counts 0..559 then reads 0; exactly 560 `psen` pulses; flags remain 0.
- Rewind: `vernier_q`=5, assert `rewind` -> 5 `psen` pulses with `psincdec`=0, `vernier_q`=0, one `rewind_done`, no `shift_done`. Rewind at `vernier_q`=0 -> no `psen`, `rewind_done` within 2 cycles.
- Timeout (PSDONE_TIMEOUT=20): psdone model silent -> `timeout_err`=1, `shift_done` 22 cycles after the `psen` cycle, `vernier_q` unchanged, next shift still accepted.
- Overrun/priority: `shift` pulsed while `busy` -> `overrun_err`=1 and step count unchanged. `rewind` and `shift` together in IDLE -> rewind executes and `overrun_err`=1.
- Settle and reset (macro on, SETTLE_CYCLES=16): `shift_done` delayed by 17 cycles versus macro off. `reset` asserted during WAIT -> next cycle all outputs 0, state IDLE, no `shift_done`.
